// File: rtl/ili9341_pixel_gen.sv
`timescale 1ns/1ps
// ILI9341 test-pattern source: raster-scans an H_RES x V_RES frame and paints a
// mood-coloured background with an inverted (optionally blinking) box.
module ili9341_pixel_gen #(
  parameter int H_RES        = 320,
  parameter int V_RES        = 240,
  parameter int BOX_X0       = 110,
  parameter int BOX_Y0       = 70,
  parameter int BOX_W        = 100,
  parameter int BOX_H        = 100,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                       clk_input_data,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [2:0]                 mood,
  output logic [15:0]                pixel_data,
  output logic [$clog2(H_RES)-1:0]   pixel_x,
  output logic [$clog2(V_RES)-1:0]   pixel_y,
  output logic                       frame_done,
  output logic [0:0]                 o_dbg_state
);

  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);
  localparam int FW = (2 * BLINK_FRAMES > 2) ? $clog2(2 * BLINK_FRAMES) : 1;

  localparam logic [0:0] ST_WAIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [XW-1:0] X_LAST  = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(V_RES - 1);
  localparam logic [XW-1:0] BX_LO   = XW'(BOX_X0);
  localparam logic [XW-1:0] BX_HI   = XW'(BOX_X0 + BOX_W - 1);
  localparam logic [YW-1:0] BY_LO   = YW'(BOX_Y0);
  localparam logic [YW-1:0] BY_HI   = YW'(BOX_Y0 + BOX_H - 1);
  localparam logic [FW-1:0] FC_LAST = FW'(2 * BLINK_FRAMES - 1);
  localparam logic [FW-1:0] FC_HALF = FW'(BLINK_FRAMES);

  if (H_RES < 2 || V_RES < 2) begin : g_bad_frame
    $error("ili9341_pixel_gen: frame must be at least 2x2");
  end
  if (BOX_W < 1 || BOX_H < 1 || BOX_X0 < 0 || BOX_Y0 < 0 ||
      BOX_X0 + BOX_W > H_RES || BOX_Y0 + BOX_H > V_RES) begin : g_bad_box
    $error("ili9341_pixel_gen: box does not fit inside the frame");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("ili9341_pixel_gen: BLINK_FRAMES must be at least 1");
  end

  logic [0:0]    r_state;
  logic [15:0]   r_pixel_data;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_frame_done;
  logic [2:0]    r_active_mood;
  logic [FW-1:0] r_frame_cnt;

  logic [XW-1:0] w_nx;
  logic [YW-1:0] w_ny;
  logic          w_at_origin;
  logic          w_last;
  logic [2:0]    w_mood;
  logic [15:0]   w_bg;
  logic          w_in_box;
  logic          w_blank;
  logic [15:0]   w_colour;

  function automatic logic [15:0] f_bg(input logic [2:0] m);
    case (m)
      3'd0:    f_bg = 16'hFFE0;
      3'd1:    f_bg = 16'h07FF;
      3'd2:    f_bg = 16'hF800;
      3'd3:    f_bg = 16'h780F;
      3'd4:    f_bg = 16'h0000;
      default: f_bg = 16'h001F;
    endcase
  endfunction

  // Position the next edge will present; leaving WAIT always starts at the origin.
  always_comb begin
    w_nx = '0;
    w_ny = '0;
    if (r_state == ST_RUN) begin
      if (r_x == X_LAST) begin
        w_nx = '0;
        w_ny = (r_y == Y_LAST) ? '0 : r_y + 1'b1;
      end else begin
        w_nx = r_x + 1'b1;
        w_ny = r_y;
      end
    end
  end

  // The origin pixel already uses the freshly sampled mood, so colour and latch agree.
  always_comb begin
    w_at_origin = (w_nx == '0) && (w_ny == '0);
    w_last      = (w_nx == X_LAST) && (w_ny == Y_LAST);
    w_mood      = w_at_origin ? mood : r_active_mood;
    w_bg        = f_bg(w_mood);
    w_in_box    = (w_nx >= BX_LO) && (w_nx <= BX_HI) &&
                  (w_ny >= BY_LO) && (w_ny <= BY_HI);
    w_blank     = (w_mood == 3'd2) && (r_frame_cnt >= FC_HALF);
    w_colour    = (w_in_box && !w_blank) ? ~w_bg : w_bg;
  end

  always_ff @(posedge clk_input_data) begin
    if (!rst) begin
      r_state       <= ST_WAIT;
      r_pixel_data  <= 16'h0000;
      r_x           <= '0;
      r_y           <= '0;
      r_frame_done  <= 1'b0;
      r_active_mood <= 3'd0;
      r_frame_cnt   <= '0;
    end else begin
      r_frame_done <= 1'b0;
      if (enable) begin
        r_state      <= ST_RUN;
        r_x          <= w_nx;
        r_y          <= w_ny;
        r_pixel_data <= w_colour;
        r_frame_done <= w_last;
        if (w_at_origin) begin
          r_active_mood <= mood;
        end
        if (w_last) begin
          r_frame_cnt <= (r_frame_cnt == FC_LAST) ? '0 : r_frame_cnt + 1'b1;
        end
      end
    end
  end

  assign pixel_data  = r_pixel_data;
  assign pixel_x     = r_x;
  assign pixel_y     = r_y;
  assign frame_done  = r_frame_done;
  assign o_dbg_state = r_state;

endmodule

// File: doc/ili9341_pixel_gen.md
ILI9341_PIXEL_GEN -- requirements
Module: ili9341_pixel_gen

Interface
REQ-001 Parameter H_RES, default 320, pixels per line.
REQ-002 Parameter V_RES, default 240, lines per frame.
REQ-003 Parameters BOX_X0/BOX_Y0/BOX_W/BOX_H, defaults 110/70/100/100, the foreground box's origin and size in pixels.
REQ-004 Parameter BLINK_FRAMES, default 30, frames per blink half-period.
REQ-005 clk_input_data  input  1  pixel clock; one pixel is produced per rising edge while advancing.
REQ-006 rst  input  1  synchronous, active-low reset.
REQ-007 enable  input  1  1 = advance the pixel stream; 0 = hold all outputs.
REQ-008 mood  input  3  requested display mood, 0..4 valid.
REQ-009 pixel_data  output  16  RGB565 colour of the current pixel.
REQ-010 pixel_x  output  $clog2(H_RES)  column of pixel_data.
REQ-011 pixel_y  output  $clog2(V_RES)  row of pixel_data.
REQ-012 frame_done  output  1  high for exactly the cycle presenting the last pixel of a frame.

Function
REQ-013 The block SHALL contain a 2-state FSM: WAIT (after reset, until enable=1 is first sampled) and RUN; RUN never returns to WAIT except through reset.
REQ-014 In WAIT, the outputs SHALL hold their reset values; the first enable=1 edge SHALL move to RUN and present pixel (0,0) at the same edge.
REQ-015 In RUN with enable=1, each edge SHALL advance the position: x+1; at x=H_RES-1, x->0 and y+1; at (H_RES-1,V_RES-1), wrap to (0,0).
REQ-016 In RUN with enable=0, pixel_data, pixel_x, pixel_y, the frame counter and the latched mood SHALL hold; frame_done SHALL be 0.
REQ-017 pixel_data, pixel_x and pixel_y SHALL be registered together, with zero skew between colour and coordinates.
REQ-018 mood SHALL be latched into active_mood only on the edge that presents pixel (0,0); mid-frame mood changes SHALL NOT affect the current frame.
REQ-019 Background colour from active_mood: 0 -> FFE0, 1 -> 07FF, 2 -> F800, 3 -> 780F, 4 -> 0000, 5..7 -> 001F.
REQ-020 A pixel is in the box when BOX_X0 <= x <= BOX_X0+BOX_W-1 and BOX_Y0 <= y <= BOX_Y0+BOX_H-1 (inclusive edges).
REQ-021 A box pixel SHALL be coloured with the bitwise inverse of the background colour, except where REQ-023 blanks it.
REQ-022 The frame counter SHALL count modulo 2*BLINK_FRAMES and increment on each frame_done edge.
REQ-023 When active_mood=2 and frame counter >= BLINK_FRAMES, box pixels SHALL show background colour.
REQ-024 frame_done SHALL be 1 only when presenting (H_RES-1,V_RES-1) on an advancing edge; one cycle wide.
REQ-025 Box parameters SHALL lie within the frame; otherwise elaboration SHALL fail.

Reset
REQ-026 rst=0 at an edge SHALL force: FSM=WAIT, pixel_data=0000, pixel_x=0, pixel_y=0, frame_done=0, active_mood=0, frame counter=0.
REQ-027 Reset SHALL take priority over enable, including mid-frame; the next frame SHALL restart at (0,0).

Verification
REQ-028 Reset, then enable=1 with mood=0 -> first pixel (0,0)=FFE0; pixel (110,70)=001F; pixel (209,169)=001F; pixel (210,170)=FFE0.
REQ-029 Enable steady for 76800 cycles -> frame_done high only at cycle 76800 on (319,239); next edge presents (0,0).
REQ-030 mood changed 0->3 at pixel (5,100) -> rest of frame keeps FFE0/001F; next frame background 780F, box 87F0.
REQ-031 mood=2 for 60 frames -> box 07FF in frames 0..29, F800 (blank) in frames 30..59, 07FF again in frame 60.
REQ-032 enable=0 for 10 cycles at (319,5) -> outputs frozen; resume -> (0,6); mood=6 -> background 001F, box FFE0.
REQ-033 rst=0 at pixel (200,120) -> next edge outputs 0000/(0,0)/frame_done=0; enable=1 after release -> frame restarts at (0,0).
